// File: rtl/alu_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : alu_op_sequencer
// Brief    : Four-state issue stage that reads an 8x16 register file, drives
//            an external ALU, captures its result and writes it back.
// Revision : 1.0 - initial release
// ============================================================================
module alu_op_sequencer #(
    parameter int DW   = 16,
    parameter int NREG = 8,
    parameter int AW   = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [3:0]    cmd_op,
    input  logic [AW-1:0] cmd_rd,
    input  logic [AW-1:0] cmd_rs1,
    input  logic [AW-1:0] cmd_rs2,
    input  logic          ld_en,
    input  logic [AW-1:0] ld_addr,
    input  logic [DW-1:0] ld_data,
    output logic [DW-1:0] alu_a,
    output logic [DW-1:0] alu_b,
    output logic [3:0]    alu_sel,
    input  logic [DW-1:0] alu_out,
    input  logic          alu_carry,
    output logic          res_valid,
    output logic [DW-1:0] res_data,
    output logic          res_carry,
    output logic [AW-1:0] res_rd
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_EXEC = 2'd2,
        S_WB   = 2'd3
    } state_t;

    state_t        r_state;
    logic [DW-1:0] r_rf [NREG];
    logic [3:0]    r_op;
    logic [AW-1:0] r_rd;
    logic [AW-1:0] r_rs1;
    logic [AW-1:0] r_rs2;
    logic [DW-1:0] r_alu_a;
    logic [DW-1:0] r_alu_b;
    logic [3:0]    r_alu_sel;
    logic          r_res_valid;
    logic [DW-1:0] r_res_data;
    logic          r_res_carry;
    logic [AW-1:0] r_res_rd;

    // Ready must drop while reset is asserted, even if the state is already IDLE.
    assign cmd_ready = (r_state == S_IDLE) && !rst;

    assign alu_a     = r_alu_a;
    assign alu_b     = r_alu_b;
    assign alu_sel   = r_alu_sel;
    assign res_valid = r_res_valid;
    assign res_data  = r_res_data;
    assign res_carry = r_res_carry;
    assign res_rd    = r_res_rd;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            for (int i = 0; i < NREG; i++) begin
                r_rf[i] <= '0;
            end
            r_op        <= '0;
            r_rd        <= '0;
            r_rs1       <= '0;
            r_rs2       <= '0;
            r_alu_a     <= '0;
            r_alu_b     <= '0;
            r_alu_sel   <= '0;
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
            r_res_carry <= 1'b0;
            r_res_rd    <= '0;
        end else begin
            r_res_valid <= 1'b0;

            // Direct load comes first so a same-edge write-back overrides it.
            if (ld_en && (ld_addr != '0)) begin
                r_rf[ld_addr] <= ld_data;
            end

            case (r_state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        r_op    <= cmd_op;
                        r_rd    <= cmd_rd;
                        r_rs1   <= cmd_rs1;
                        r_rs2   <= cmd_rs2;
                        r_state <= S_READ;
                    end
                end
                S_READ: begin
                    r_alu_a   <= (r_rs1 == '0) ? '0 : r_rf[r_rs1];
                    r_alu_b   <= (r_rs2 == '0) ? '0 : r_rf[r_rs2];
                    r_alu_sel <= r_op;
                    r_state   <= S_EXEC;
                end
                S_EXEC: begin
                    r_res_data  <= alu_out;
                    r_res_carry <= alu_carry;
                    r_res_rd    <= r_rd;
                    r_res_valid <= 1'b1;
                    r_state     <= S_WB;
                end
                S_WB: begin
                    if (r_rd != '0) begin
                        r_rf[r_rd] <= r_res_data;
                    end
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_op_sequencer
// Brief    : Directed table-driven bench for alu_op_sequencer with an ALU model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_op_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [3:0]  cmd_op;
    logic [2:0]  cmd_rd;
    logic [2:0]  cmd_rs1;
    logic [2:0]  cmd_rs2;
    logic        ld_en;
    logic [2:0]  ld_addr;
    logic [15:0] ld_data;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [3:0]  alu_sel;
    logic [15:0] alu_out;
    logic        alu_carry;
    logic        res_valid;
    logic [15:0] res_data;
    logic        res_carry;
    logic [2:0]  res_rd;

    alu_op_sequencer #(.DW(16), .NREG(8), .AW(3)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_rd(cmd_rd), .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
        .alu_out(alu_out), .alu_carry(alu_carry),
        .res_valid(res_valid), .res_data(res_data), .res_carry(res_carry), .res_rd(res_rd)
    );

    always #5 clk = ~clk;

    // ALU model: 0 add, 1 sub (carry = borrow), 2 and, 3 or, 4 xor, 7 shl, else pass A.
    always_comb begin
        alu_out   = alu_a;
        alu_carry = 1'b0;
        case (alu_sel)
            4'h0: {alu_carry, alu_out} = {1'b0, alu_a} + {1'b0, alu_b};
            4'h1: {alu_carry, alu_out} = {1'b0, alu_a} - {1'b0, alu_b};
            4'h2: alu_out = alu_a & alu_b;
            4'h3: alu_out = alu_a | alu_b;
            4'h4: alu_out = alu_a ^ alu_b;
            4'h7: {alu_carry, alu_out} = {alu_a, 1'b0};
            default: ;
        endcase
    end

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic        do_ld;
        logic [2:0]  la;
        logic [15:0] ldat;
        logic [3:0]  op;
        logic [2:0]  rd;
        logic [2:0]  rs1;
        logic [2:0]  rs2;
        logic [15:0] exp_d;
        logic        exp_c;
    } vec_t;

    vec_t tbl [14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [2:0] a, input logic [15:0] d);
        ld_en = 1'b1; ld_addr = a; ld_data = d;
        tick();
        ld_en = 1'b0;
    endtask

    // ph: 0 no extra load, 1 load during READ, 2 load during WB.
    task automatic issue(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                         input logic [2:0] rs2, input int ph, input logic [2:0] la,
                         input logic [15:0] ldv, output logic [15:0] d, output logic c,
                         output logic [2:0] r, output int lat, output logic one_cycle);
        int n;
        cmd_op = op; cmd_rd = rd; cmd_rs1 = rs1; cmd_rs2 = rs2; cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 20) begin tick(); n++; end
        tick();
        cmd_valid = 1'b0;
        lat = 1;
        if (ph == 1) begin ld_en = 1'b1; ld_addr = la; ld_data = ldv; end
        while (!res_valid && lat < 12) begin tick(); ld_en = 1'b0; lat++; end
        d = res_data; c = res_carry; r = res_rd;
        if (ph == 2) begin ld_en = 1'b1; ld_addr = la; ld_data = ldv; end
        tick();
        ld_en = 1'b0;
        one_cycle = !res_valid;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [15:0] d, d1;
        logic        c, p, got1, pv;
        logic [2:0]  r;
        int          lat, n, t0, t1;

        tbl[0]  = '{1'b1, 3'd1, 16'h1234, 4'h3, 3'd6, 3'd1, 3'd0, 16'h1234, 1'b0};
        tbl[1]  = '{1'b1, 3'd2, 16'h0F0F, 4'h0, 3'd3, 3'd1, 3'd2, 16'h2143, 1'b0};
        tbl[2]  = '{1'b0, 3'd0, 16'h0000, 4'h3, 3'd6, 3'd3, 3'd0, 16'h2143, 1'b0};
        tbl[3]  = '{1'b0, 3'd0, 16'h0000, 4'h4, 3'd5, 3'd1, 3'd2, 16'h1D3B, 1'b0};
        tbl[4]  = '{1'b0, 3'd0, 16'h0000, 4'h1, 3'd7, 3'd2, 3'd1, 16'hFCDB, 1'b1};
        tbl[5]  = '{1'b0, 3'd0, 16'h0000, 4'h7, 3'd4, 3'd1, 3'd0, 16'h2468, 1'b0};
        tbl[6]  = '{1'b1, 3'd2, 16'h0001, 4'h3, 3'd6, 3'd2, 3'd0, 16'h0001, 1'b0};
        tbl[7]  = '{1'b1, 3'd1, 16'hFFFF, 4'h0, 3'd4, 3'd1, 3'd2, 16'h0000, 1'b1};
        tbl[8]  = '{1'b0, 3'd0, 16'h0000, 4'h1, 3'd5, 3'd2, 3'd1, 16'h0002, 1'b1};
        tbl[9]  = '{1'b0, 3'd0, 16'h0000, 4'h3, 3'd6, 3'd4, 3'd5, 16'h0002, 1'b0};
        tbl[10] = '{1'b1, 3'd1, 16'h8001, 4'h7, 3'd0, 3'd1, 3'd0, 16'h0002, 1'b1};
        tbl[11] = '{1'b0, 3'd0, 16'h0000, 4'h3, 3'd7, 3'd0, 3'd0, 16'h0000, 1'b0};
        tbl[12] = '{1'b1, 3'd0, 16'hAAAA, 4'h3, 3'd7, 3'd0, 3'd0, 16'h0000, 1'b0};
        tbl[13] = '{1'b0, 3'd0, 16'h0000, 4'hF, 3'd2, 3'd1, 3'd0, 16'h8001, 1'b0};

        rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_rd = '0; cmd_rs1 = '0; cmd_rs2 = '0;
        ld_en = 1'b0; ld_addr = '0; ld_data = '0;
        tick(); tick();
        check("rst_ready_low", {31'b0, cmd_ready}, 32'd0);
        check("rst_res_valid", {31'b0, res_valid}, 32'd0);
        check("rst_alu_a", {16'b0, alu_a}, 32'd0);
        check("rst_res_data", {16'b0, res_data}, 32'd0);
        rst = 1'b0;
        #1;
        check("rst_ready_after", {31'b0, cmd_ready}, 32'd1);

        for (int i = 0; i < 14; i++) begin
            if (tbl[i].do_ld) load(tbl[i].la, tbl[i].ldat);
            issue(tbl[i].op, tbl[i].rd, tbl[i].rs1, tbl[i].rs2, 0, 3'd0, 16'h0, d, c, r, lat, p);
            check($sformatf("v%0d_latency", i), lat, 32'd3);
            check($sformatf("v%0d_data", i), {16'b0, d}, {16'b0, tbl[i].exp_d});
            check($sformatf("v%0d_carry", i), {31'b0, c}, {31'b0, tbl[i].exp_c});
            check($sformatf("v%0d_rd", i), {29'b0, r}, {29'b0, tbl[i].rd});
            check($sformatf("v%0d_sel", i), {28'b0, alu_sel}, {28'b0, tbl[i].op});
            check($sformatf("v%0d_strobe", i), {31'b0, p}, 32'd1);
        end

        // Back-to-back commands with cmd_valid held high; second reads the fresh R3.
        load(3'd1, 16'hFFFF);
        load(3'd2, 16'h0001);
        cmd_op = 4'h2; cmd_rd = 3'd3; cmd_rs1 = 3'd1; cmd_rs2 = 3'd2; cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 20) begin tick(); n++; end
        tick();
        t0 = cyc;
        cmd_op = 4'h3; cmd_rd = 3'd6; cmd_rs1 = 3'd3; cmd_rs2 = 3'd0;
        n = 0; got1 = 1'b0; d1 = '0;
        while (!cmd_ready && n < 10) begin
            tick(); n++;
            if (res_valid) begin got1 = 1'b1; d1 = res_data; end
        end
        tick();
        t1 = cyc;
        cmd_valid = 1'b0;
        check("b2b_accept_gap", t1 - t0, 32'd4);
        check("b2b_first_seen", {31'b0, got1}, 32'd1);
        check("b2b_first_data", {16'b0, d1}, 32'h0001);
        n = 0;
        while (!res_valid && n < 10) begin tick(); n++; end
        check("b2b_second_data", {16'b0, res_data}, 32'h0001);
        check("b2b_second_rd", {29'b0, res_rd}, 32'd6);

        // Load and write-back to R3 at the same edge: write-back wins.
        issue(4'h3, 3'd3, 3'd1, 3'd2, 2, 3'd3, 16'h5555, d, c, r, lat, p);
        check("wbld_data", {16'b0, d}, 32'hFFFF);
        issue(4'h3, 3'd6, 3'd3, 3'd0, 0, 3'd0, 16'h0, d, c, r, lat, p);
        check("wbld_r3", {16'b0, d}, 32'hFFFF);

        // Load to R1 during READ of R1: the old value is used, the new one lands.
        issue(4'h3, 3'd5, 3'd1, 3'd0, 1, 3'd1, 16'h1234, d, c, r, lat, p);
        check("readld_old", {16'b0, d}, 32'hFFFF);
        issue(4'h3, 3'd6, 3'd1, 3'd0, 0, 3'd0, 16'h0, d, c, r, lat, p);
        check("readld_new", {16'b0, d}, 32'h1234);

        // Reset during EXEC abandons the command.
        cmd_op = 4'h3; cmd_rd = 3'd5; cmd_rs1 = 3'd1; cmd_rs2 = 3'd0; cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 20) begin tick(); n++; end
        tick();
        cmd_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        check("mid_rst_ready", {31'b0, cmd_ready}, 32'd0);
        check("mid_rst_valid", {31'b0, res_valid}, 32'd0);
        check("mid_rst_res_data", {16'b0, res_data}, 32'd0);
        check("mid_rst_alu_sel", {28'b0, alu_sel}, 32'd0);
        check("mid_rst_res_rd", {29'b0, res_rd}, 32'd0);
        rst = 1'b0;
        #1;
        check("mid_rst_ready_after", {31'b0, cmd_ready}, 32'd1);
        pv = 1'b0;
        repeat (4) begin tick(); pv = pv | res_valid; end
        check("mid_rst_no_pulse", {31'b0, pv}, 32'd0);
        for (int k = 1; k < 8; k++) begin
            issue(4'h3, 3'd0, k[2:0], 3'd0, 0, 3'd0, 16'h0, d, c, r, lat, p);
            check($sformatf("post_rst_r%0d", k), {16'b0, d}, 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
